ct_byte_serializer: RTL and testbench



---
 rtl/ct_byte_serializer.sv | 149 ++++++++++++++
 tb/tb_ct_byte_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_byte_serializer.sv
// Captures a ciphertext frame on ct_done and drains it MSB-first as a byte stream.
// Optional trailing CRC-8 byte when CT_SERIALIZER_CRC_EN is defined.
module ct_byte_serializer #(
    parameter int CT_WIDTH = 297
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [CT_WIDTH-1:0] ciphertext,
    input  logic                ct_done,
    output logic [7:0]          byte_out,
    output logic                byte_valid,
    input  logic                byte_ready,
    output logic                byte_last,
    output logic                busy,
    output logic                overflow,
    output logic [1:0]          dbg_state
);

    localparam int NBYTES = (CT_WIDTH + 7) / 8;
    localparam int PADW   = 8 * NBYTES;
    localparam int PAD    = PADW - CT_WIDTH;
    localparam logic [5:0] LAST_IDX = 6'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_CRC  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PADW-1:0] sreg_q, sreg_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            hs;
    logic            frame_end;
    logic [PADW-1:0] padded;

`ifdef CT_SERIALIZER_CRC_EN
    logic [7:0] crc_q, crc_d;

    // CRC-8, poly 0x07, MSB first, one whole byte per call.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    assign padded    = PADW'(ciphertext) << PAD;
    assign dbg_state = state_q;

    // Handshake: a byte moves on any rising edge where byte_valid && byte_ready;
    // outputs depend only on flops, and valid holds until that edge.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        byte_valid = (state_q != S_IDLE);
        busy       = (state_q != S_IDLE);
        byte_out   = 8'h00;
        byte_last  = 1'b0;
        overflow   = ovf_q;
`ifdef CT_SERIALIZER_CRC_EN
        crc_d      = crc_q;
`endif

        unique case (state_q)
            S_SEND: begin
                byte_out = sreg_q[PADW-1 -: 8];
`ifndef CT_SERIALIZER_CRC_EN
                byte_last = (cnt_q == LAST_IDX);
`endif
            end
`ifdef CT_SERIALIZER_CRC_EN
            S_CRC: begin
                byte_out  = crc_q;
                byte_last = 1'b1;
            end
`endif
            default: ;
        endcase

        hs        = byte_valid & byte_ready;
        frame_end = hs & byte_last;

        unique case (state_q)
            S_SEND: begin
                if (hs) begin
                    sreg_d = sreg_q << 8;
`ifdef CT_SERIALIZER_CRC_EN
                    crc_d = crc8_next(crc_q, sreg_q[PADW-1 -: 8]);
`endif
                    if (cnt_q == LAST_IDX) begin
`ifdef CT_SERIALIZER_CRC_EN
                        state_d = S_CRC;
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            S_CRC: begin
                if (hs) state_d = S_IDLE;
            end
            default: ;
        endcase

        // A new frame may enter only when the block is idle or finishing this edge.
        if (ct_done) begin
            if (state_q == S_IDLE || frame_end) begin
                sreg_d  = padded;
                cnt_d   = 6'd0;
                state_d = S_SEND;
`ifdef CT_SERIALIZER_CRC_EN
                crc_d   = 8'h00;
`endif
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef CT_SERIALIZER_CRC_EN
            crc_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
`ifdef CT_SERIALIZER_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_ct_byte_serializer.sv
// Directed bench for ct_byte_serializer: vector table plus hand-written corner sequences.
module tb_ct_byte_serializer;

`ifdef CT_SERIALIZER_CRC_EN
    localparam int FLEN = 39;
`else
    localparam int FLEN = 38;
`endif

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic [296:0] ciphertext = '0;
    logic         ct_done = 1'b0;
    logic [7:0]   byte_out;
    logic         byte_valid;
    logic         byte_ready = 1'b0;
    logic         byte_last;
    logic         busy;
    logic         overflow;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [296:0] ct;
        logic [7:0]   b0;
        logic [7:0]   mid;
        logic [7:0]   b37;
        int           mode;
    } vec_t;

    vec_t vecs[5];

    ct_byte_serializer #(.CT_WIDTH(297)) dut (
        .clk(clk), .rst_b(rst_b), .ciphertext(ciphertext), .ct_done(ct_done),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_last(byte_last), .busy(busy), .overflow(overflow), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [296:0] ct, input int k);
        logic [303:0] p;
        p = {ct, 7'b0};
        return p[303-8*k -: 8];
    endfunction

    // Bit-serial reference CRC over the padded frame.
    function automatic logic [7:0] crc_ref(input logic [296:0] ct);
        logic [303:0] p;
        logic [7:0]   c;
        logic         fb;
        p = {ct, 7'b0};
        c = 8'h00;
        for (int i = 303; i >= 0; i--) begin
            fb = c[7] ^ p[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic push_model(input logic [296:0] ct);
        for (int k = 0; k < 38; k++) exp_q.push_back(byte_of(ct, k));
`ifdef CT_SERIALIZER_CRC_EN
        exp_q.push_back(crc_ref(ct));
`endif
    endtask

    task automatic push_hand(input vec_t v);
        exp_q.push_back(v.b0);
        for (int k = 1; k < 37; k++) exp_q.push_back(v.mid);
        exp_q.push_back(v.b37);
`ifdef CT_SERIALIZER_CRC_EN
        exp_q.push_back(crc_ref(v.ct));
`endif
    endtask

    task automatic start_frame(input logic [296:0] ct);
        @(negedge clk);
        ct_done    = 1'b1;
        ciphertext = ct;
        @(negedge clk);
        ct_done = 1'b0;
        check("start_valid", 32'(byte_valid), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
    endtask

    // Runs at negedges; mode 0 = ready always 1, mode 1 = ready 1,0,0 pattern.
    task automatic drain(input int mode, input int ovf_at, input bit b2b,
                         input logic [296:0] ct2, output int cycles);
        int         idx = 0;
        int         cyc = 0;
        bit         pending = 0;
        bit         pulsed = 0;
        logic [7:0] prev_b = 8'h00;
        logic       prev_l = 1'b0;
        logic [7:0] e;
        while (idx < FLEN && cyc < 400) begin
            byte_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            ct_done = 1'b0;
            if (idx == ovf_at && !pulsed) begin
                ct_done    = 1'b1;
                ciphertext = '0;
                pulsed     = 1;
            end
            check("valid_held", 32'(byte_valid), 32'd1);
            if (pending) begin
                check("stable_byte", 32'(byte_out), 32'(prev_b));
                check("stable_last", 32'(byte_last), 32'(prev_l));
            end
            if (byte_ready) begin
                if (exp_q.size() == 0) begin
                    check("queue_empty", 32'(byte_out), 32'hFFFF_FFFF);
                    e = 8'h00;
                end else begin
                    e = exp_q.pop_front();
                end
                check($sformatf("byte%0d", idx), 32'(byte_out), 32'(e));
                check($sformatf("last%0d", idx), 32'(byte_last), 32'(idx == FLEN - 1));
                if (b2b && idx == FLEN - 1) begin
                    ct_done    = 1'b1;
                    ciphertext = ct2;
                end
                idx++;
                pending = 0;
            end else begin
                pending = 1;
                prev_b  = byte_out;
                prev_l  = byte_last;
            end
            cyc++;
            @(negedge clk);
        end
        ct_done    = 1'b0;
        byte_ready = 1'b0;
        if (idx < FLEN) check("drain_timeout", 32'(idx), 32'(FLEN));
        cycles = cyc;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(byte_valid), 32'd0);
        check({tag, "_last"}, 32'(byte_last), 32'd0);
    endtask

    initial begin
        int           cycles;
        logic [319:0] r;
        logic [296:0] ct_a, ct_b;

        vecs[0] = '{ct: {297{1'b1}},          b0: 8'hFF, mid: 8'hFF, b37: 8'h80, mode: 0};
        vecs[1] = '{ct: 297'd1 << 296,        b0: 8'h80, mid: 8'h00, b37: 8'h00, mode: 0};
        vecs[2] = '{ct: 297'd1,               b0: 8'h00, mid: 8'h00, b37: 8'h80, mode: 1};
        vecs[3] = '{ct: '0,                   b0: 8'h00, mid: 8'h00, b37: 8'h00, mode: 1};
        vecs[4] = '{ct: 297'hA5 << 289,       b0: 8'hA5, mid: 8'h00, b37: 8'h00, mode: 0};

        repeat (2) @(negedge clk);
        check("rst_byte", 32'(byte_out), 32'h0);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_last", 32'(byte_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_b = 1'b1;

        for (int i = 0; i < 5; i++) begin
            push_hand(vecs[i]);
            start_frame(vecs[i].ct);
            drain(vecs[i].mode, -1, 1'b0, '0, cycles);
            if (vecs[i].mode == 0) check($sformatf("frame_cycles%0d", i), 32'(cycles), 32'(FLEN));
            check_idle($sformatf("idle%0d", i));
            check($sformatf("ovf_clear%0d", i), 32'(overflow), 32'd0);
        end

        // Dropped ct_done mid-frame.
        push_model({297{1'b1}});
        start_frame({297{1'b1}});
        drain(0, 5, 1'b0, '0, cycles);
        check_idle("ovf_idle");
        check("ovf_set", 32'(overflow), 32'd1);

        // Back-to-back frames.
        ct_a = {10{32'h1357_9BDF}};
        ct_b = {10{32'hC0FF_EE42}};
        push_model(ct_a);
        push_model(ct_b);
        start_frame(ct_a);
        drain(0, -1, 1'b1, ct_b, cycles);
        check("b2b_valid", 32'(byte_valid), 32'd1);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_byte0", 32'(byte_out), 32'(byte_of(ct_b, 0)));
        drain(0, -1, 1'b0, '0, cycles);
        check_idle("b2b_idle");

        // Reset mid-frame at byte 10.
        start_frame({297{1'b1}});
        byte_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("pre_rst_valid", 32'(byte_valid), 32'd1);
        rst_b = 1'b0;
        #1;
        check("mrst_byte", 32'(byte_out), 32'h0);
        check("mrst_valid", 32'(byte_valid), 32'd0);
        check("mrst_last", 32'(byte_last), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(byte_valid), 32'd0);
        check("post_rst_byte", 32'(byte_out), 32'h0);
        byte_ready = 1'b0;
        exp_q.delete();
        push_model(297'd1 << 296);
        start_frame(297'd1 << 296);
        drain(0, -1, 1'b0, '0, cycles);
        check_idle("rst_frame_idle");

        // Random frame; exercises the CRC reference when enabled.
        for (int w = 0; w < 10; w++) r[w*32 +: 32] = $urandom;
        ct_a = r[296:0];
        push_model(ct_a);
        start_frame(ct_a);
        drain(1, -1, 1'b0, '0, cycles);
        check_idle("rand_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
